pwm_light_controller: RTL and testbench
=======================================

// Module: pwm_light_controller
// PURPOSE
//  Mode sequencer and PWM generator for the light stand. Divides i_clk into a PWM
//  tick, steps through OFF/LOW/MID/HIGH on button presses, and drives the lamp PWM.
//  Sits between the debounced button input and the lamp driver pin.
//  Duty changes take effect only at PWM period boundaries, so the output never glitches.
// PARAMETERS
//  PRESCALE    50   i_clk cycles per PWM tick (>=2)
//  PWM_PERIOD  100  PWM ticks per PWM period; duty is expressed in ticks (0..PWM_PERIOD)
//  DUTY_LOW    25   duty for LOW mode
//  DUTY_MID    50   duty for MID mode
//  DUTY_HIGH   100  duty for HIGH mode
//  FADE_STEP   1    duty change per period boundary when the fade feature is built
//  Localparam DUTY_W = $clog2(PWM_PERIOD+1)
// PORTS
//  i_clk           in   1       system clock
//  i_reset         in   1       synchronous reset, active-high
//  i_btn           in   1       debounced button level; each rising edge advances the mode
//  o_pwm           out  1       lamp PWM output, registered
//  o_mode          out  2       current mode: 0 OFF, 1 LOW, 2 MID, 3 HIGH
//  o_duty          out  DUTY_W  duty currently applied to o_pwm
//  o_period_start  out  1       1-cycle pulse on the cycle the PWM counter wraps to 0
//  o_fading        out  1       high while o_duty != target duty (fade build only)
// BEHAVIOUR
//  Reset (synchronous, sampled on posedge i_clk): prescaler, PWM counter, btn history,
//   o_mode, o_duty, o_pwm, o_period_start, o_fading all 0; btn history = 0.
//  Prescaler: r_pre counts 0..PRESCALE-1 and wraps. tick = (r_pre == PRESCALE-1).
//  PWM counter: r_cnt increments on tick and wraps PWM_PERIOD-1 -> 0.
//   boundary = tick && r_cnt == PWM_PERIOD-1. o_period_start is registered from boundary.
//  Output: o_pwm <= (r_cnt < o_duty) every cycle, so latency is 1 clock.
//   duty 0 -> constant 0; duty PWM_PERIOD -> constant 1.
//  Button: btn_q <= i_btn. press = i_btn && !btn_q. A held button gives exactly one press.
//  Mode FSM: OFF -> LOW -> MID -> HIGH -> OFF, one step per press.
//   o_mode updates on the clock edge at which press is true.
//   target = {0, DUTY_LOW, DUTY_MID, DUTY_HIGH}[o_mode].
//  Duty update happens only at a boundary. Multiple presses within one period: the
//   latest mode's target is applied at the next boundary.
//  Simultaneous press and boundary: the boundary uses the target of the pre-press mode.
//   The new target applies at the following boundary.
//  Reset mid-period: all state clears on that edge. The first period after reset
//   starts at r_cnt = 0.
//  Duty parameters > PWM_PERIOD are illegal (the bench asserts on this).
// CONFIGURATION
//  Macro PWM_LIGHT_FADE_EN.
//  Defined: at each boundary, o_duty moves toward target by FADE_STEP, clamped so it
//   never overshoots target. o_fading = (o_duty != target), registered.
//   A mode change mid-fade redirects toward the new target from the current o_duty.
//  Undefined: at each boundary, o_duty <= target in one step. o_fading is tied to 0.
// TESTING
//  Defaults used throughout: 1 PWM period = 5000 i_clk cycles.
//  1. Assert reset, then run 12000 cycles with no press.
//     -> o_mode=0, o_duty=0, o_pwm=0 throughout.
//     -> o_period_start pulses every 5000 cycles.
//  2. One press (i_btn high 10 cycles).
//     -> o_mode=1 on the cycle after the rise.
//     -> o_duty=25 from the next boundary.
//     -> o_pwm high for 1250 of each 5000 cycles, starting 1 cycle after o_period_start.
//  3. Four presses spaced 100 cycles apart.
//     -> o_mode sequence 1,2,3,0; final o_duty=0.
//     -> 3 presses: o_mode=3, o_duty=100, o_pwm held 1 for a full period.
//  4. i_btn held high for 20000 cycles.
//     -> exactly one mode advance.
//  5. Assert i_reset for 1 cycle mid-period while in HIGH.
//     -> next cycle o_mode=0, o_duty=0, o_pwm=0.
//     -> o_period_start 5000 cycles after release.
//  6. PWM_LIGHT_FADE_EN: OFF -> LOW.
//     -> o_duty steps 1,2,...,25 at successive boundaries.
//     -> o_fading high until o_duty=25, then low.
//     Press again at o_duty=10: o_duty rises toward 50.

Source files
------------

// File: rtl/pwm_light_controller.sv
// Light stand mode sequencer and PWM generator: button presses step OFF/LOW/MID/HIGH.
// Optional duty fading between modes is built when PWM_LIGHT_FADE_EN is defined.
module pwm_light_controller #(
    parameter int PRESCALE   = 50,
    parameter int PWM_PERIOD = 100,
    parameter int DUTY_LOW   = 25,
    parameter int DUTY_MID   = 50,
    parameter int DUTY_HIGH  = 100,
    parameter int FADE_STEP  = 1,
    localparam int DUTY_W    = $clog2(PWM_PERIOD + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn,
    output logic              o_pwm,
    output logic [1:0]        o_mode,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_period_start,
    output logic              o_fading
);

    localparam int PRE_W = $clog2(PRESCALE);

    // A step of at least a full period lands on the target in a single boundary.
`ifdef PWM_LIGHT_FADE_EN
    localparam int STEP = FADE_STEP;
`else
    localparam int STEP = (FADE_STEP > PWM_PERIOD) ? FADE_STEP : PWM_PERIOD;
`endif

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_MID  = 2'd2,
        MODE_HIGH = 2'd3
    } mode_t;

    mode_t             mode_q;
    mode_t             mode_d;
    logic [PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] target_cur;
    logic              btn_q;
    logic              press;
    logic              tick;
    logic              boundary;

    function automatic logic [DUTY_W-1:0] target_of(input mode_t m);
        case (m)
            MODE_LOW:  return DUTY_W'(DUTY_LOW);
            MODE_MID:  return DUTY_W'(DUTY_MID);
            MODE_HIGH: return DUTY_W'(DUTY_HIGH);
            default:   return '0;
        endcase
    endfunction

    assign tick       = (r_pre == PRE_W'(PRESCALE - 1));
    assign boundary   = tick && (r_cnt == DUTY_W'(PWM_PERIOD - 1));
    assign press      = i_btn && !btn_q;
    assign target_cur = target_of(mode_q);
    assign o_mode     = mode_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre          <= '0;
            r_cnt          <= '0;
            btn_q          <= 1'b0;
            o_period_start <= 1'b0;
            o_pwm          <= 1'b0;
            o_duty         <= '0;
            mode_q         <= MODE_OFF;
        end else begin
            r_pre          <= tick ? '0 : r_pre + 1'b1;
            if (tick) begin
                r_cnt <= (r_cnt == DUTY_W'(PWM_PERIOD - 1)) ? '0 : r_cnt + 1'b1;
            end
            btn_q          <= i_btn;
            o_period_start <= boundary;
            o_pwm          <= (r_cnt < o_duty);
            o_duty         <= duty_d;
            mode_q         <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press) begin
            case (mode_q)
                MODE_OFF:  mode_d = MODE_LOW;
                MODE_LOW:  mode_d = MODE_MID;
                MODE_MID:  mode_d = MODE_HIGH;
                default:   mode_d = MODE_OFF;
            endcase
        end
    end

    // The boundary reads the pre-press mode, so a coincident press waits one period.
    always_comb begin
        duty_d = o_duty;
        if (boundary) begin
            if (int'(target_cur) > int'(o_duty) + STEP) begin
                duty_d = o_duty + DUTY_W'(STEP);
            end else if (int'(target_cur) + STEP < int'(o_duty)) begin
                duty_d = o_duty - DUTY_W'(STEP);
            end else begin
                duty_d = target_cur;
            end
        end
    end

`ifdef PWM_LIGHT_FADE_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fading <= 1'b0;
        end else begin
            o_fading <= (duty_d != target_of(mode_d));
        end
    end
`else
    assign o_fading = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_light_controller.sv
// Scoreboard bench for pwm_light_controller: stimulus queues per-period expectations,
// a negedge monitor checks them at every o_period_start pulse.
module tb_pwm_light_controller;

    localparam int PRE    = 10;
    localparam int PER    = 100;
    localparam int PCYC   = PRE * PER;
    localparam int D_LOW  = 25;
    localparam int D_MID  = 50;
    localparam int D_HIGH = 100;
    localparam int DW     = $clog2(PER + 1);
`ifdef PWM_LIGHT_FADE_EN
    localparam int STEP = 1;
`else
    localparam int STEP = PER;
`endif

    typedef struct {
        int mode;
        int duty;
        int fading;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn;
    logic          pwm;
    logic [1:0]    mode;
    logic [DW-1:0] duty;
    logic          pstart;
    logic          fading;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_duty = 0;
    int   last_duty = 0;
    int   hi_cnt = 0;
    int   len_cnt = 0;
    bit   primed = 1'b0;

    always #5 clk = ~clk;

    pwm_light_controller #(
        .PRESCALE  (PRE),
        .PWM_PERIOD(PER),
        .DUTY_LOW  (D_LOW),
        .DUTY_MID  (D_MID),
        .DUTY_HIGH (D_HIGH),
        .FADE_STEP (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_btn         (btn),
        .o_pwm         (pwm),
        .o_mode        (mode),
        .o_duty        (duty),
        .o_period_start(pstart),
        .o_fading      (fading)
    );

    initial begin
        assert (D_LOW <= PER && D_MID <= PER && D_HIGH <= PER)
        else $fatal(1, "[TB] FAIL duty_param_range: a duty exceeds %0d", PER);
    end

    function automatic int target_of(input int m);
        case (m)
            1:       return D_LOW;
            2:       return D_MID;
            3:       return D_HIGH;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // mode_used is the mode in force just before the boundary edge; mode_shown is after it.
    task automatic expectPeriod(input int mode_shown, input int mode_used);
        exp_t e;
        int   t;
        t = target_of(mode_used);
        if (model_duty < t) model_duty = (t - model_duty > STEP) ? model_duty + STEP : t;
        else if (model_duty > t) model_duty = (model_duty - t > STEP) ? model_duty - STEP : t;
        e.mode = mode_shown;
        e.duty = model_duty;
`ifdef PWM_LIGHT_FADE_EN
        e.fading = int'(model_duty != target_of(mode_shown));
`else
        e.fading = 0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic waitPulse();
        int n = 0;
        @(negedge clk);
        while (!pstart && n < 2 * PCYC) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pulse_seen", int'(pstart), 1);
        #1;
    endtask

    // One button press held for hold_cycles clock edges; checks the mode one cycle after the rise.
    task automatic applyStimulus(input int hold_cycles, input int exp_mode);
        @(posedge clk);
        #1 btn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mode_after_press", int'(mode), exp_mode);
        repeat (hold_cycles - 1) @(posedge clk);
        #1 btn = 1'b0;
    endtask

    task automatic applyReset();
        int n = 0;
        exp_q.delete();
        model_duty = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        expectPeriod(0, 0);
        @(negedge clk);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_duty", int'(duty), 0);
        checkOutput("reset_pwm", int'(pwm), 0);
        while (!pstart && n < 2 * PCYC) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reset_to_first_pulse", n, PCYC);
        #1;
    endtask

    task automatic pressSeries(input int first_mode, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(10, (first_mode + i) % 4);
            repeat (90) @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            primed  = 1'b0;
            hi_cnt  = 0;
            len_cnt = 0;
        end else begin
            len_cnt++;
            if (pwm) hi_cnt++;
            if (pstart) begin
                if (primed) begin
                    checkOutput("pwm_high_cycles", hi_cnt, last_duty * PRE);
                    checkOutput("period_length", len_cnt, PCYC);
                end
                checkOutput("expectation_available", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("mode_at_boundary", int'(mode), e.mode);
                    checkOutput("duty_at_boundary", int'(duty), e.duty);
                    checkOutput("fading_at_boundary", int'(fading), e.fading);
                    last_duty = e.duty;
                end
                primed  = 1'b1;
                hi_cnt  = 0;
                len_cnt = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        repeat (3) @(posedge clk);
        applyReset();
`ifdef PWM_LIGHT_FADE_EN
        applyStimulus(10, 1);
        for (int i = 0; i < 10; i++) begin
            expectPeriod(1, 1);
            waitPulse();
        end
        applyStimulus(10, 2);
        for (int i = 0; i < 5; i++) begin
            expectPeriod(2, 2);
            waitPulse();
        end
        applyReset();
        applyStimulus(10, 1);
        for (int i = 0; i < 26; i++) begin
            expectPeriod(1, 1);
            waitPulse();
        end
`else
        // Idle after reset: lamp stays dark, pulses keep their period.
        repeat (2) begin
            expectPeriod(0, 0);
            waitPulse();
        end
        applyStimulus(10, 1);
        repeat (2) begin
            expectPeriod(1, 1);
            waitPulse();
        end
        pressSeries(2, 3);
        expectPeriod(0, 0);
        waitPulse();
        pressSeries(1, 3);
        repeat (2) begin
            expectPeriod(3, 3);
            waitPulse();
        end
        // A long hold across two boundaries must advance the mode only once.
        expectPeriod(0, 0);
        expectPeriod(0, 0);
        applyStimulus(2500, 0);
        checkOutput("mode_after_long_hold", int'(mode), 0);
        expectPeriod(0, 0);
        waitPulse();
        pressSeries(1, 3);
        expectPeriod(3, 3);
        waitPulse();
        repeat (300) @(posedge clk);
        applyReset();
        // Press lands on the boundary edge: new mode shows, old duty is applied.
        expectPeriod(1, 0);
        repeat (PCYC - 2) @(posedge clk);
        applyStimulus(5, 1);
        expectPeriod(1, 1);
        waitPulse();
`endif
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
